// File: rtl/pcie_consts.sv
// Shared constants and bundle types for the queue-table port-b path.
// Table selects, requester ids, arbiter FSM states and read tags.
package pcie_consts;

  localparam int RB_AWIDTH_DEF = 16;
  localparam int NB_TABLES = 4;

  typedef enum logic [1:0] {
    TBL_TAILS   = 2'd0,
    TBL_HEADS   = 2'd1,
    TBL_L_ADDRS = 2'd2,
    TBL_H_ADDRS = 2'd3
  } q_table_sel_t;

  typedef enum logic {
    REQ_PCIE = 1'b0,
    REQ_JTAG = 1'b1
  } requester_t;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic         wr;
    q_table_sel_t tbl;
    logic [31:0]  data;
  } arb_req_t;

  typedef struct packed {
    logic         valid;
    requester_t   owner;
    q_table_sel_t tbl;
  } rd_tag_t;

  function automatic requester_t other_req(
    input requester_t r
  );
    return (r == REQ_PCIE) ? REQ_JTAG : REQ_PCIE;
  endfunction

endpackage

// File: rtl/bram_interface_io.sv
// Single BRAM port bundle: address, write and read strobes, data.
// The user side drives the strobes; the mem side returns rd_data.
interface bram_interface_io #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
);

  logic [AWIDTH-1:0] addr;
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_en;
  logic [DWIDTH-1:0] rd_data;

  modport user (
    output addr,
    output wr_en,
    output wr_data,
    output rd_en,
    input  rd_data
  );

  modport mem (
    input  addr,
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// A lone request always wins; on contention the pointer decides.
module rr_arbiter2
  import pcie_consts::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  requester_t ptr;
  requester_t winner;

  // Grant decode: at most one bit set, none while disabled.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (!en || req == 2'b00): gnt = 2'b00;
      (en && req == 2'b01):  gnt = 2'b01;
      (en && req == 2'b10):  gnt = 2'b10;
      (en && req == 2'b11):
        gnt = (ptr == REQ_PCIE) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign winner = gnt[1] ? REQ_JTAG : REQ_PCIE;

  // Pointer always moves to the side that did not win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= REQ_PCIE;
    end else if (|gnt) begin
      ptr <= other_req(winner);
    end
  end

endmodule

// File: rtl/queue_table_arbiter.sv
// Port-b owner of the four queue-state tables: init sweep, then
// round-robin PCIe/JTAG access with tagged fixed-latency reads.
module queue_table_arbiter
  import pcie_consts::*;
#(
  parameter int NB_QUEUES      = 512,
  parameter int QUEUE_ID_WIDTH = $clog2(NB_QUEUES),
  parameter int RD_LATENCY     = 2,
  parameter int RB_AWIDTH      = RB_AWIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      pcie_req_valid,
  output logic                      pcie_req_ready,
  input  logic                      pcie_req_wr,
  input  logic [1:0]                pcie_req_table,
  input  logic [QUEUE_ID_WIDTH-1:0] pcie_req_queue,
  input  logic [31:0]               pcie_req_data,
  output logic [31:0]               pcie_rd_data,
  output logic                      pcie_rd_valid,

  input  logic                      jtag_req_valid,
  output logic                      jtag_req_ready,
  input  logic                      jtag_req_wr,
  input  logic [1:0]                jtag_req_table,
  input  logic [QUEUE_ID_WIDTH-1:0] jtag_req_queue,
  input  logic [31:0]               jtag_req_data,
  output logic [31:0]               jtag_rd_data,
  output logic                      jtag_rd_valid,

  output logic                      init_done,

  bram_interface_io.user            q_table_tails,
  bram_interface_io.user            q_table_heads,
  bram_interface_io.user            q_table_l_addrs,
  bram_interface_io.user            q_table_h_addrs
);

  localparam logic [QUEUE_ID_WIDTH-1:0] LAST_Q =
    QUEUE_ID_WIDTH'(NB_QUEUES - 1);

  arb_state_t                state;
  logic [QUEUE_ID_WIDTH-1:0] sweep_cnt;
  logic                      sweeping;
  logic                      run_en;

  logic [1:0]                gnt;
  logic                      granted;
  arb_req_t                  pcie_req;
  arb_req_t                  jtag_req;
  arb_req_t                  req;
  logic [QUEUE_ID_WIDTH-1:0] req_queue;
  logic [NB_TABLES-1:0]      tbl_hit;

  logic [NB_TABLES-1:0]      tbl_wr;
  logic [NB_TABLES-1:0]      tbl_rd;
  logic [QUEUE_ID_WIDTH-1:0] addr_q;
  logic [QUEUE_ID_WIDTH-1:0] addr_nxt;
  logic [31:0]               wdata_q;
  logic [31:0]               wdata_nxt;

  rd_tag_t                   tag_pipe [RD_LATENCY];
  rd_tag_t                   tag_in;
  rd_tag_t                   tag_out;
  logic [31:0]               rd_word;

  assign sweeping = rst && (state == S_INIT);
  assign run_en   = rst && (state == S_RUN);

  // Sweep counter walks every queue once, then hands over to RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_Q) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .req ({jtag_req_valid, pcie_req_valid}),
    .gnt (gnt)
  );

  assign pcie_req_ready = gnt[0];
  assign jtag_req_ready = gnt[1];
  assign granted        = |gnt;

  assign pcie_req = '{
    wr:   pcie_req_wr,
    tbl:  q_table_sel_t'(pcie_req_table),
    data: pcie_req_data
  };

  assign jtag_req = '{
    wr:   jtag_req_wr,
    tbl:  q_table_sel_t'(jtag_req_table),
    data: jtag_req_data
  };

  assign req       = gnt[1] ? jtag_req : pcie_req;
  assign req_queue = gnt[1] ? jtag_req_queue : pcie_req_queue;
  assign tbl_hit   = NB_TABLES'(1) << req.tbl;

  // Port-b command: sweep writes, granted access, or idle hold.
  always_comb begin
    tbl_wr    = '0;
    tbl_rd    = '0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    unique case (1'b1)
      sweeping: begin
        tbl_wr    = '1;
        addr_nxt  = sweep_cnt;
        wdata_nxt = '0;
      end
      (!sweeping && granted): begin
        addr_nxt  = req_queue;
        wdata_nxt = req.data;
        if (req.wr) begin
          tbl_wr = tbl_hit;
        end else begin
          tbl_rd = tbl_hit;
        end
      end
      default: begin
        tbl_wr = '0;
      end
    endcase
  end

  // Address and write data keep their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign q_table_tails.addr      = addr_nxt;
  assign q_table_tails.wr_en     = tbl_wr[TBL_TAILS];
  assign q_table_tails.wr_data   = wdata_nxt[RB_AWIDTH-1:0];
  assign q_table_tails.rd_en     = tbl_rd[TBL_TAILS];

  assign q_table_heads.addr      = addr_nxt;
  assign q_table_heads.wr_en     = tbl_wr[TBL_HEADS];
  assign q_table_heads.wr_data   = wdata_nxt[RB_AWIDTH-1:0];
  assign q_table_heads.rd_en     = tbl_rd[TBL_HEADS];

  assign q_table_l_addrs.addr    = addr_nxt;
  assign q_table_l_addrs.wr_en   = tbl_wr[TBL_L_ADDRS];
  assign q_table_l_addrs.wr_data = wdata_nxt;
  assign q_table_l_addrs.rd_en   = tbl_rd[TBL_L_ADDRS];

  assign q_table_h_addrs.addr    = addr_nxt;
  assign q_table_h_addrs.wr_en   = tbl_wr[TBL_H_ADDRS];
  assign q_table_h_addrs.wr_data = wdata_nxt;
  assign q_table_h_addrs.rd_en   = tbl_rd[TBL_H_ADDRS];

  assign tag_in = '{
    valid: granted && !req.wr && !sweeping,
    owner: gnt[1] ? REQ_JTAG : REQ_PCIE,
    tbl:   req.tbl
  };

  // Read tags ride alongside the BRAM latency; reset drops them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[RD_LATENCY-1];

  // Pick the returning table and zero-extend it to 32 bits.
  always_comb begin
    rd_word = '0;
    unique case (tag_out.tbl)
      TBL_TAILS:   rd_word = 32'(q_table_tails.rd_data);
      TBL_HEADS:   rd_word = 32'(q_table_heads.rd_data);
      TBL_L_ADDRS: rd_word = 32'(q_table_l_addrs.rd_data);
      TBL_H_ADDRS: rd_word = 32'(q_table_h_addrs.rd_data);
      default:     rd_word = '0;
    endcase
  end

  assign pcie_rd_valid = tag_out.valid &&
                         (tag_out.owner == REQ_PCIE);
  assign jtag_rd_valid = tag_out.valid &&
                         (tag_out.owner == REQ_JTAG);
  assign pcie_rd_data  = pcie_rd_valid ? rd_word : '0;
  assign jtag_rd_data  = jtag_rd_valid ? rd_word : '0;

endmodule

// File: tb/tb_queue_table_arbiter.sv
// Randomized bench for queue_table_arbiter against a table/queue model.
// BRAMs are modelled here with a two-cycle read latency.
module tb_queue_table_arbiter;
  import pcie_consts::*;

  localparam int NBQ = 16;
  localparam int QW  = $clog2(NBQ);
  localparam int RDL = 2;
  localparam int RBW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          pcie_req_valid = 1'b0;
  logic          pcie_req_ready;
  logic          pcie_req_wr = 1'b0;
  logic [1:0]    pcie_req_table = 2'd0;
  logic [QW-1:0] pcie_req_queue = '0;
  logic [31:0]   pcie_req_data = '0;
  logic [31:0]   pcie_rd_data;
  logic          pcie_rd_valid;

  logic          jtag_req_valid = 1'b0;
  logic          jtag_req_ready;
  logic          jtag_req_wr = 1'b0;
  logic [1:0]    jtag_req_table = 2'd0;
  logic [QW-1:0] jtag_req_queue = '0;
  logic [31:0]   jtag_req_data = '0;
  logic [31:0]   jtag_rd_data;
  logic          jtag_rd_valid;

  logic          init_done;

  bram_interface_io #(.AWIDTH(QW), .DWIDTH(RBW)) tails_if ();
  bram_interface_io #(.AWIDTH(QW), .DWIDTH(RBW)) heads_if ();
  bram_interface_io #(.AWIDTH(QW), .DWIDTH(32))  laddr_if ();
  bram_interface_io #(.AWIDTH(QW), .DWIDTH(32))  haddr_if ();

  queue_table_arbiter #(
    .NB_QUEUES  (NBQ),
    .RD_LATENCY (RDL),
    .RB_AWIDTH  (RBW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pcie_req_valid  (pcie_req_valid),
    .pcie_req_ready  (pcie_req_ready),
    .pcie_req_wr     (pcie_req_wr),
    .pcie_req_table  (pcie_req_table),
    .pcie_req_queue  (pcie_req_queue),
    .pcie_req_data   (pcie_req_data),
    .pcie_rd_data    (pcie_rd_data),
    .pcie_rd_valid   (pcie_rd_valid),
    .jtag_req_valid  (jtag_req_valid),
    .jtag_req_ready  (jtag_req_ready),
    .jtag_req_wr     (jtag_req_wr),
    .jtag_req_table  (jtag_req_table),
    .jtag_req_queue  (jtag_req_queue),
    .jtag_req_data   (jtag_req_data),
    .jtag_rd_data    (jtag_rd_data),
    .jtag_rd_valid   (jtag_rd_valid),
    .init_done       (init_done),
    .q_table_tails   (tails_if),
    .q_table_heads   (heads_if),
    .q_table_l_addrs (laddr_if),
    .q_table_h_addrs (haddr_if)
  );

  always #5 clk = ~clk;

  // BRAM port-b models
  logic [3:0]    b_wr;
  logic [3:0]    b_rd;
  logic [QW-1:0] b_addr [4];
  logic [31:0]   b_wd [4];
  logic [31:0]   mem [4][NBQ];
  logic [31:0]   p1 [4];
  logic [31:0]   p2 [4];

  assign b_wr = {haddr_if.wr_en, laddr_if.wr_en,
                 heads_if.wr_en, tails_if.wr_en};
  assign b_rd = {haddr_if.rd_en, laddr_if.rd_en,
                 heads_if.rd_en, tails_if.rd_en};
  assign b_addr[0] = tails_if.addr;
  assign b_addr[1] = heads_if.addr;
  assign b_addr[2] = laddr_if.addr;
  assign b_addr[3] = haddr_if.addr;
  assign b_wd[0] = 32'(tails_if.wr_data);
  assign b_wd[1] = 32'(heads_if.wr_data);
  assign b_wd[2] = laddr_if.wr_data;
  assign b_wd[3] = haddr_if.wr_data;

  always @(posedge clk) begin
    for (int t = 0; t < 4; t++) begin
      if (b_wr[t]) mem[t][b_addr[t]] <= b_wd[t];
      p1[t] <= b_rd[t] ? mem[t][b_addr[t]] : 32'hdead_beef;
      p2[t] <= p1[t];
    end
  end

  assign tails_if.rd_data = p2[0][RBW-1:0];
  assign heads_if.rd_data = p2[1][RBW-1:0];
  assign laddr_if.rd_data = p2[2];
  assign haddr_if.rd_data = p2[3];

  // Reference model
  typedef struct {
    bit        wr;
    bit [1:0]  tbl;
    int        q;
    bit [31:0] data;
  } req_s;

  typedef struct {
    longint    due;
    bit        who;
    bit [31:0] data;
  } rsp_s;

  req_s      pq[$];
  req_s      jq[$];
  rsp_s      rq[$];
  bit [31:0] ref_mem [4][NBQ];
  bit        ref_ptr;
  bit        in_init;
  int        sweep_idx;
  longint    cyc;
  int        n_checks;
  int        n_fail;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic bit [31:0] tmask(bit [1:0] tbl);
    return (tbl < 2) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  function automatic req_s mk(bit wr, bit [1:0] tbl,
                              int q, bit [31:0] data);
    req_s r;
    r.wr = wr;
    r.tbl = tbl;
    r.q = q;
    r.data = data;
    return r;
  endfunction

  function automatic req_s rand_req();
    return mk(1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)),
              int'($urandom_range(0, NBQ - 1)),
              $urandom);
  endfunction

  task automatic tick(bit r);
    bit        vp, vj, gp, gj, evp, evj;
    bit [31:0] ed;
    bit [3:0]  ewr, erd;
    req_s      g;
    rsp_s      done;
    @(negedge clk);
    rst = r;
    vp = pq.size() > 0;
    vj = jq.size() > 0;
    pcie_req_valid = vp;
    jtag_req_valid = vj;
    if (vp) begin
      pcie_req_wr    = pq[0].wr;
      pcie_req_table = pq[0].tbl;
      pcie_req_queue = QW'(pq[0].q);
      pcie_req_data  = pq[0].data;
    end else begin
      pcie_req_wr    = 1'($urandom);
      pcie_req_table = 2'($urandom);
      pcie_req_queue = QW'($urandom);
      pcie_req_data  = $urandom;
    end
    if (vj) begin
      jtag_req_wr    = jq[0].wr;
      jtag_req_table = jq[0].tbl;
      jtag_req_queue = QW'(jq[0].q);
      jtag_req_data  = jq[0].data;
    end else begin
      jtag_req_wr    = 1'($urandom);
      jtag_req_table = 2'($urandom);
      jtag_req_queue = QW'($urandom);
      jtag_req_data  = $urandom;
    end
    #2;
    evp = 1'b0;
    evj = 1'b0;
    ed  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      done = rq.pop_front();
      evp = !done.who;
      evj = done.who;
      ed  = done.data;
    end
    chk("pcie_rd_valid", 32'(pcie_rd_valid), 32'(evp));
    chk("jtag_rd_valid", 32'(jtag_rd_valid), 32'(evj));
    if (evp) chk("pcie_rd_data", pcie_rd_data, ed);
    if (evj) chk("jtag_rd_data", jtag_rd_data, ed);
    gp = 1'b0;
    gj = 1'b0;
    if (!r) begin
      chk("rst_ready", 32'({pcie_req_ready, jtag_req_ready}), 32'd0);
      rq.delete();
      ref_ptr   = 1'b0;
      in_init   = 1'b1;
      sweep_idx = 0;
    end else if (in_init) begin
      chk("init_done_lo", 32'(init_done), 32'd0);
      chk("init_ready", 32'({pcie_req_ready, jtag_req_ready}), 32'd0);
      chk("init_wr_en", 32'(b_wr), 32'hf);
      chk("init_rd_en", 32'(b_rd), 32'h0);
      for (int t = 0; t < 4; t++) begin
        chk("init_addr", 32'(b_addr[t]), 32'(sweep_idx));
        chk("init_wdata", b_wd[t], 32'd0);
        ref_mem[t][sweep_idx] = '0;
      end
      sweep_idx++;
      if (sweep_idx == NBQ) in_init = 1'b0;
    end else begin
      chk("init_done_hi", 32'(init_done), 32'd1);
      if (vp && vj) begin
        gp = !ref_ptr;
        gj = ref_ptr;
      end else begin
        gp = vp;
        gj = vj;
      end
      if (gp) ref_ptr = 1'b1;
      else if (gj) ref_ptr = 1'b0;
      chk("pcie_ready", 32'(pcie_req_ready), 32'(gp));
      chk("jtag_ready", 32'(jtag_req_ready), 32'(gj));
      ewr = '0;
      erd = '0;
      if (gp || gj) begin
        g = gp ? pq[0] : jq[0];
        chk("addr", 32'(b_addr[g.tbl]), 32'(g.q));
        if (g.wr) begin
          ewr[g.tbl] = 1'b1;
          chk("wr_data", b_wd[g.tbl], g.data & tmask(g.tbl));
          ref_mem[g.tbl][g.q] = g.data & tmask(g.tbl);
        end else begin
          erd[g.tbl] = 1'b1;
          rq.push_back('{due: cyc + RDL, who: gj,
                         data: ref_mem[g.tbl][g.q]});
        end
      end
      chk("wr_en", 32'(b_wr), 32'(ewr));
      chk("rd_en", 32'(b_rd), 32'(erd));
      if (gp) void'(pq.pop_front());
      if (gj) void'(jq.pop_front());
    end
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic flush();
    run(pq.size() + jq.size() + RDL + 2);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    ref_ptr   = 1'b0;
    in_init   = 1'b1;
    sweep_idx = 0;
    repeat (2) @(posedge clk);

    // Reset, then a PCIe read held across the whole sweep.
    pq.push_back(mk(1'b0, TBL_TAILS, 0, 0));
    tick(1'b0);
    tick(1'b0);
    run(NBQ + 1);
    flush();

    // Write heads q3 then read it back (truncated to 16 bits).
    pq.push_back(mk(1'b1, TBL_HEADS, 3, 32'h1234_5678));
    pq.push_back(mk(1'b0, TBL_HEADS, 3, 0));
    flush();

    // Contention on l_addrs q1/q2.
    pq.push_back(mk(1'b1, TBL_L_ADDRS, 1, 32'hcafe_0001));
    pq.push_back(mk(1'b1, TBL_L_ADDRS, 2, 32'hcafe_0002));
    flush();
    pq.push_back(mk(1'b0, TBL_L_ADDRS, 1, 0));
    pq.push_back(mk(1'b0, TBL_L_ADDRS, 2, 0));
    jq.push_back(mk(1'b0, TBL_L_ADDRS, 1, 0));
    jq.push_back(mk(1'b0, TBL_L_ADDRS, 2, 0));
    flush();

    // JTAG back-to-back reads of h_addrs q0..7.
    for (int i = 0; i < 8; i++)
      pq.push_back(mk(1'b1, TBL_H_ADDRS, i, $urandom));
    flush();
    for (int i = 0; i < 8; i++)
      jq.push_back(mk(1'b0, TBL_H_ADDRS, i, 0));
    flush();

    // Per-table isolation on q5.
    pq.push_back(mk(1'b1, TBL_TAILS, 5, 32'h0000_00aa));
    pq.push_back(mk(1'b0, TBL_HEADS, 5, 0));
    pq.push_back(mk(1'b0, TBL_L_ADDRS, 5, 0));
    pq.push_back(mk(1'b0, TBL_H_ADDRS, 5, 0));
    pq.push_back(mk(1'b0, TBL_TAILS, 5, 0));
    flush();

    // Reset with a read tag in flight, then reset at sweep count 2.
    pq.push_back(mk(1'b0, TBL_TAILS, 5, 0));
    tick(1'b1);
    tick(1'b0);
    run(2);
    tick(1'b0);
    run(NBQ);
    pq.push_back(mk(1'b0, TBL_TAILS, 5, 0));
    flush();

    // Random traffic with rare resets.
    repeat (3000) begin
      if (pq.size() < 2 && $urandom_range(0, 2) != 0)
        pq.push_back(rand_req());
      if (jq.size() < 2 && $urandom_range(0, 2) != 0)
        jq.push_back(rand_req());
      tick($urandom_range(0, 499) != 0);
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_table_arbiter.md
Name: queue_table_arbiter

Overview:
- Owns port b of the four packet-queue state BRAMs (tails, heads, low addrs, high addrs) and shares it between two requesters: the PCIe MMIO register path and the JTAG debug path.
- After reset it first runs an init sweep that zeroes every entry of all four tables, then arbitrates single-table read/write requests round-robin.
- It returns read data to the issuing requester with a fixed, tagged latency.

Parameters:
- NB_QUEUES, 512, number of queues (entries per table).
- QUEUE_ID_WIDTH, $clog2(NB_QUEUES), queue index width.
- RD_LATENCY, 2, BRAM port-b read latency in cycles.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, synchronous, active-low.
- pcie_req_valid  input  1  PCIe request valid.
- pcie_req_ready  output  1  PCIe request accepted this cycle.
- pcie_req_wr  input  1  1 = write, 0 = read.
- pcie_req_table  input  2  table select (TBL_TAILS/HEADS/L_ADDRS/H_ADDRS).
- pcie_req_queue  input  QUEUE_ID_WIDTH  queue index.
- pcie_req_data  input  32  write data.
- pcie_rd_data  output  32  read response data, zero-extended.
- pcie_rd_valid  output  1  read response valid, one-cycle pulse.
- jtag_req_valid, jtag_req_ready, jtag_req_wr, jtag_req_table, jtag_req_queue, jtag_req_data, jtag_rd_data, jtag_rd_valid: same directions, widths and meanings as the PCIe set.
- init_done  output  1  high once the init sweep has completed.
- q_table_tails, q_table_heads, q_table_l_addrs, q_table_h_addrs  bram_interface_io.user  -  port b of each queue table (addr, wr_en, wr_data, rd_en, rd_data).

Behaviour:
- Reset (rst == 0 at a clk edge):
  - FSM -> INIT, sweep counter = 0, init_done = 0, rr pointer = PCIe.
  - Response pipeline cleared; all rd_valid = 0, both req_ready = 0.
  - Outstanding read responses are dropped, never delivered.
- INIT state:
  - Each cycle drives wr_en = 1, addr = counter, wr_data = 0 on all four tables; counter increments.
  - After the write to NB_QUEUES-1 the FSM moves to RUN, and init_done = 1 from the next cycle.
  - The sweep takes exactly NB_QUEUES cycles.
  - Both req_ready = 0 throughout INIT.
  - Reset asserted mid-sweep restarts the sweep from 0.
- RUN state, arbitration:
  - At most one grant per cycle; req_ready is combinational and equals the grant.
  - Only one valid requester: it is granted.
  - Both valid: the requester indicated by the rr pointer is granted, and the pointer moves to the other requester.
  - A lone grant also sets the pointer to the other requester.
  - Requests must hold stable while valid and not ready.
- Granted write:
  - Same cycle: the selected table gets wr_en = 1, addr = queue, wr_data = req_data truncated to the table width (RB_AWIDTH for tails/heads, 32 for addrs).
  - Unselected tables get wr_en = 0 and rd_en = 0.
  - No response is returned.
- Granted read:
  - Same cycle: the selected table gets rd_en = 1, addr = queue.
  - A tag {valid, requester, table} enters an RD_LATENCY-deep shift register.
  - When the tag exits, the owning requester sees rd_valid = 1 and rd_data = that table's rd_data, zero-extended to 32.
  - Latency is exactly RD_LATENCY cycles from grant to rd_valid.
  - Back-to-back reads from either requester are accepted every cycle with no bubbles.
- Responses have no backpressure; requesters must always accept them.
- Idle cycles: all rd_en = 0 and wr_en = 0. addr/wr_data hold their last value and are don't-care.
- Same-cycle collision with port a (the queue_manager side) is not handled here; the owning module bypasses on port a.

Decomposition:
- Shared package (pcie_consts): table-select constants TBL_TAILS = 0, TBL_HEADS = 1, TBL_L_ADDRS = 2, TBL_H_ADDRS = 3. Add the enum typedef q_table_sel_t and the arbiter request struct typedef.
- Sub-module rr_arbiter2 (2-input round-robin grant with pointer): natural to factor out and reusable.

Test Plan:
- Init sweep, NB_QUEUES = 4: release rst at cycle 0.
  - Writes to queues 0,1,2,3 occur on all four tables at cycles 0–3 with data 0.
  - init_done = 1 at cycle 4.
  - A pcie_req_valid held high from cycle 0 is first granted at cycle 4.
- PCIe write then read: write head q = 3, data 0x1234_5678 with RB_AWIDTH = 16, then read head q = 3 one cycle later.
  - pcie_rd_valid pulses 2 cycles after the read grant.
  - pcie_rd_data = 0x0000_5678.
- Contention: PCIe and JTAG both valid for 4 cycles, each issuing reads of l_addrs q = 1 and q = 2.
  - Grants alternate PCIe, JTAG, PCIe, JTAG.
  - Each response is routed to the correct rd_valid with the matching data.
- Back-to-back reads: JTAG reads h_addrs for q = 0..7 on consecutive cycles.
  - 8 consecutive jtag_rd_valid pulses with data in order, first at grant + 2.
- Reset mid-operation:
  - Reset during a read with the tag in flight: no rd_valid is ever produced for that read.
  - Reset at sweep counter = 2: the sweep restarts at queue 0 and init_done stays 0 until NB_QUEUES cycles after release.
- Per-table isolation: write 0xAA to tails q = 5, then read heads, l_addrs and h_addrs for q = 5.
  - All three reads return 0, since only the tails table was written.
